// File: rtl/clk_div_ratio_monitor.sv
// clk_div_ratio_monitor
//   Consumer-side checker for a divided clock. div_clk is synchronised into the
//   clk domain and every rising edge closes a period measurement in clk cycles.
//   Lock is declared after LOCK_CNT consecutive in-tolerance periods. A period
//   that is out of tolerance pulses ratio_err. A divider that stops toggling
//   pulses timeout once.
//
// Ports
//   clk         in   1  source clock, posedge
//   rst         in   1  asynchronous, active-high reset
//   div_clk     in   1  divided clock under test (asynchronous)
//   period      out  W  last measured period, valid with period_vld
//   period_vld  out  1  one-cycle pulse, new period measurement
//   locked      out  1  level, ratio stable and within tolerance
//   ratio_err   out  1  one-cycle pulse, measured period out of tolerance
//   timeout     out  1  one-cycle pulse, no rise within 2*DIV clk cycles
//
// FSM states
//   state   | meaning
//   IDLE    | no reference edge yet; the next rise only starts a measurement
//   ACQUIRE | measuring, counting consecutive good periods toward lock
//   LOCKED  | ratio confirmed; any bad period or stall drops lock
module clk_div_ratio_monitor #(
  parameter int DIV      = 4,
  parameter int TOL      = 0,
  parameter int LOCK_CNT = 3,
  localparam int W       = $clog2(2*DIV+1)
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         div_clk,
  output logic [W-1:0] period,
  output logic         period_vld,
  output logic         locked,
  output logic         ratio_err,
  output logic         timeout
);

  localparam int GW = $clog2(LOCK_CNT+1);

  localparam logic [W-1:0]  CNT_ONE   = W'(1);
  localparam logic [W-1:0]  CNT_MAX   = '1;
  localparam logic [W-1:0]  TO_VAL    = W'(2*DIV);
  localparam logic [W:0]    DIV_X     = (W+1)'(DIV);
  localparam logic [W:0]    TOL_X     = (W+1)'(TOL);
  localparam logic [GW-1:0] LOCK_LAST = GW'(LOCK_CNT-1);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ACQUIRE = 2'd1,
    LOCKED  = 2'd2
  } state_t;

  state_t        state_q, state_d;
  logic [GW-1:0] good_cnt_q, good_cnt_d;
  logic          s1, s2, s3;
  logic          rise;
  logic [W-1:0]  cnt;
  logic [W:0]    diff;
  logic          good;

  logic [W-1:0]  period_d;
  logic          period_vld_d, locked_d, ratio_err_d, timeout_d;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1 <= 1'b0;
      s2 <= 1'b0;
      s3 <= 1'b0;
    end else begin
      s1 <= div_clk;
      s2 <= s1;
      s3 <= s2;
    end
  end

  assign rise = s2 & ~s3;

  // Saturating counter so a long stall cannot wrap around and look like a
  // plausible period.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt <= '0;
    end else if (rise) begin
      cnt <= CNT_ONE;
    end else if (cnt != CNT_MAX) begin
      cnt <= cnt + 1'b1;
    end
  end

  // Absolute deviation computed one bit wider so neither branch can wrap.
  always_comb begin
    if ({1'b0, cnt} >= DIV_X) begin
      diff = {1'b0, cnt} - DIV_X;
    end else begin
      diff = DIV_X - {1'b0, cnt};
    end
    good = (diff <= TOL_X);
  end

  always_comb begin
    state_d      = state_q;
    good_cnt_d   = good_cnt_q;
    period_d     = period;
    period_vld_d = 1'b0;
    locked_d     = locked;
    ratio_err_d  = 1'b0;
    timeout_d    = 1'b0;

    case (state_q)
      IDLE: begin
        if (rise) begin
          state_d    = ACQUIRE;
          good_cnt_d = '0;
        end
      end

      ACQUIRE: begin
        // A rise always takes priority over the timeout compare.
        if (rise) begin
          period_d     = cnt;
          period_vld_d = 1'b1;
          if (good) begin
            good_cnt_d = good_cnt_q + 1'b1;
            if (good_cnt_q == LOCK_LAST) begin
              state_d  = LOCKED;
              locked_d = 1'b1;
            end
          end else begin
            ratio_err_d = 1'b1;
            good_cnt_d  = '0;
          end
        end else if (cnt == TO_VAL) begin
          timeout_d = 1'b1;
          state_d   = IDLE;
        end
      end

      LOCKED: begin
        if (rise) begin
          period_d     = cnt;
          period_vld_d = 1'b1;
          if (!good) begin
            ratio_err_d = 1'b1;
            locked_d    = 1'b0;
            good_cnt_d  = '0;
            state_d     = ACQUIRE;
          end
        end else if (cnt == TO_VAL) begin
          timeout_d = 1'b1;
          locked_d  = 1'b0;
          state_d   = IDLE;
        end
      end

      default: begin
        state_d    = IDLE;
        good_cnt_d = '0;
        locked_d   = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      good_cnt_q <= '0;
      period     <= '0;
      period_vld <= 1'b0;
      locked     <= 1'b0;
      ratio_err  <= 1'b0;
      timeout    <= 1'b0;
    end else begin
      state_q    <= state_d;
      good_cnt_q <= good_cnt_d;
      period     <= period_d;
      period_vld <= period_vld_d;
      locked     <= locked_d;
      ratio_err  <= ratio_err_d;
      timeout    <= timeout_d;
    end
  end

endmodule

// File: tb/tb_clk_div_ratio_monitor.sv
// Testbench for clk_div_ratio_monitor. Two instances: DIV=4/TOL=0/LOCK_CNT=3 for
// most scenarios and DIV=4/TOL=1/LOCK_CNT=3 for the tolerance scenario. Rises
// are driven on the falling clk edge; expected output events (with the cycle
// they must appear in) are queued as stimulus is driven, and events seen on the
// DUT outputs are collected and compared in each test task.
module tb_clk_div_ratio_monitor;

  localparam int DIV = 4;
  localparam int W   = $clog2(2*DIV+1);

  logic         clk = 1'b0;
  logic         rst = 1'b0;
  logic         div_clk = 1'b0;
  logic         div_clk_t = 1'b0;
  logic [W-1:0] period, period_t;
  logic         period_vld, locked, ratio_err, timeout;
  logic         period_vld_t, locked_t, ratio_err_t, timeout_t;

  clk_div_ratio_monitor #(.DIV(DIV), .TOL(0), .LOCK_CNT(3)) u_dut (
    .clk(clk), .rst(rst), .div_clk(div_clk), .period(period),
    .period_vld(period_vld), .locked(locked), .ratio_err(ratio_err), .timeout(timeout)
  );

  clk_div_ratio_monitor #(.DIV(DIV), .TOL(1), .LOCK_CNT(3)) u_dut_tol (
    .clk(clk), .rst(rst), .div_clk(div_clk_t), .period(period_t),
    .period_vld(period_vld_t), .locked(locked_t), .ratio_err(ratio_err_t), .timeout(timeout_t)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int   cyc;
    int   per;
    logic vld;
    logic err;
    logic to;
    logic lck;
  } evt_t;

  evt_t exp_q[$], obs_q[$], exp_t_q[$], obs_t_q[$];

  int vectors = 0;
  int miscompares = 0;
  int last_gap = 0;
  int last_rise = 0;
  bit use_t = 1'b0;

  always @(negedge clk) begin
    if (period_vld || ratio_err || timeout)
      obs_q.push_back('{cyc, int'(period), period_vld, ratio_err, timeout, locked});
    if (period_vld_t || ratio_err_t || timeout_t)
      obs_t_q.push_back('{cyc, int'(period_t), period_vld_t, ratio_err_t, timeout_t, locked_t});
  end

  // Called at a falling edge: drive a rise now, hold the level for p cycles in
  // total so the next call lands exactly p cycles later. The queued event is
  // the one this rise produces, measuring the previous gap; it appears three
  // clk edges after the drive.
  task automatic rise_hold(input int p, input bit vld, input bit err, input bit lck);
    int   h;
    evt_t e;
    h = (p / 2 < 1) ? 1 : p / 2;
    last_rise = cyc;
    if (vld) begin
      e = '{cyc + 3, last_gap, 1'b1, err, 1'b0, lck};
      if (use_t) exp_t_q.push_back(e);
      else exp_q.push_back(e);
    end
    if (use_t) div_clk_t = 1'b1;
    else div_clk = 1'b1;
    repeat (h) @(negedge clk);
    if (use_t) div_clk_t = 1'b0;
    else div_clk = 1'b0;
    repeat (p - h) @(negedge clk);
    last_gap = p;
  endtask

  // Timeout follows the last rise by 3 edges of pipeline plus 2*DIV counts.
  task automatic push_timeout();
    evt_t e;
    e = '{last_rise + 3 + 2*DIV, 0, 1'b0, 1'b0, 1'b1, 1'b0};
    if (use_t) exp_t_q.push_back(e);
    else exp_q.push_back(e);
  endtask

  task automatic test_reset();
    #2 rst = 1'b1;
    #1;
    vectors++;
    if ({period, period_vld, locked, ratio_err, timeout} !== '0) begin
      miscompares++;
      $display("FAIL reset_async: got %b, exp 0", {period, period_vld, locked, ratio_err, timeout});
    end
    vectors++;
    if ({period_t, period_vld_t, locked_t, ratio_err_t, timeout_t} !== '0) begin
      miscompares++;
      $display("FAIL reset_async_tol: got %b, exp 0", {period_t, period_vld_t, locked_t, ratio_err_t, timeout_t});
    end
    repeat (3) @(negedge clk);
    vectors++;
    if ({period, period_vld, locked, ratio_err, timeout} !== '0) begin
      miscompares++;
      $display("FAIL reset_held: got %b, exp 0", {period, period_vld, locked, ratio_err, timeout});
    end
    rst = 1'b0;
  endtask

  task automatic test_steady();
    evt_t e, o;
    rise_hold(4, 0, 0, 0);
    rise_hold(4, 1, 0, 0);
    rise_hold(4, 1, 0, 0);
    rise_hold(4, 1, 0, 1);
    rise_hold(4, 1, 0, 1);
    rise_hold(4, 1, 0, 1);
    for (int n = 0; n < 16 && obs_q.size() < exp_q.size(); n++) @(negedge clk);
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      vectors++;
      if (obs_q.size() == 0) begin
        miscompares++;
        $display("FAIL steady: got no event, exp event at cyc=%0d", e.cyc);
      end else begin
        o = obs_q.pop_front();
        if (o.cyc !== e.cyc || o.vld !== e.vld || o.err !== e.err || o.to !== e.to || o.lck !== e.lck || (e.vld && o.per !== e.per)) begin
          miscompares++;
          $display("FAIL steady: got cyc=%0d per=%0d vld=%b err=%b to=%b lck=%b, exp cyc=%0d per=%0d vld=%b err=%b to=%b lck=%b",
                   o.cyc, o.per, o.vld, o.err, o.to, o.lck, e.cyc, e.per, e.vld, e.err, e.to, e.lck);
        end
      end
    end
    vectors++;
    if (obs_q.size() != 0) begin
      miscompares++;
      $display("FAIL steady_extra: got %0d unexpected events, exp 0", obs_q.size());
      obs_q.delete();
    end
  endtask

  task automatic test_stretch();
    evt_t e, o;
    rise_hold(5, 1, 0, 1);
    rise_hold(4, 1, 1, 0);
    rise_hold(4, 1, 0, 0);
    rise_hold(4, 1, 0, 0);
    rise_hold(4, 1, 0, 1);
    for (int n = 0; n < 16 && obs_q.size() < exp_q.size(); n++) @(negedge clk);
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      vectors++;
      if (obs_q.size() == 0) begin
        miscompares++;
        $display("FAIL stretch: got no event, exp event at cyc=%0d", e.cyc);
      end else begin
        o = obs_q.pop_front();
        if (o.cyc !== e.cyc || o.vld !== e.vld || o.err !== e.err || o.to !== e.to || o.lck !== e.lck || (e.vld && o.per !== e.per)) begin
          miscompares++;
          $display("FAIL stretch: got cyc=%0d per=%0d vld=%b err=%b to=%b lck=%b, exp cyc=%0d per=%0d vld=%b err=%b to=%b lck=%b",
                   o.cyc, o.per, o.vld, o.err, o.to, o.lck, e.cyc, e.per, e.vld, e.err, e.to, e.lck);
        end
      end
    end
    vectors++;
    if (obs_q.size() != 0) begin
      miscompares++;
      $display("FAIL stretch_extra: got %0d unexpected events, exp 0", obs_q.size());
      obs_q.delete();
    end
  endtask

  task automatic test_stall();
    evt_t e, o;
    rise_hold(20, 1, 0, 1);
    push_timeout();
    rise_hold(4, 0, 0, 0);
    rise_hold(4, 1, 0, 0);
    rise_hold(4, 1, 0, 0);
    rise_hold(4, 1, 0, 1);
    for (int n = 0; n < 16 && obs_q.size() < exp_q.size(); n++) @(negedge clk);
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      vectors++;
      if (obs_q.size() == 0) begin
        miscompares++;
        $display("FAIL stall: got no event, exp event at cyc=%0d", e.cyc);
      end else begin
        o = obs_q.pop_front();
        if (o.cyc !== e.cyc || o.vld !== e.vld || o.err !== e.err || o.to !== e.to || o.lck !== e.lck || (e.vld && o.per !== e.per)) begin
          miscompares++;
          $display("FAIL stall: got cyc=%0d per=%0d vld=%b err=%b to=%b lck=%b, exp cyc=%0d per=%0d vld=%b err=%b to=%b lck=%b",
                   o.cyc, o.per, o.vld, o.err, o.to, o.lck, e.cyc, e.per, e.vld, e.err, e.to, e.lck);
        end
      end
    end
    vectors++;
    if (obs_q.size() != 0) begin
      miscompares++;
      $display("FAIL stall_extra: got %0d unexpected events, exp 0", obs_q.size());
      obs_q.delete();
    end
  endtask

  task automatic test_rise_on_timeout();
    evt_t e, o;
    rise_hold(8, 1, 0, 1);
    rise_hold(4, 1, 1, 0);
    rise_hold(4, 1, 0, 0);
    rise_hold(4, 1, 0, 0);
    rise_hold(4, 1, 0, 1);
    for (int n = 0; n < 16 && obs_q.size() < exp_q.size(); n++) @(negedge clk);
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      vectors++;
      if (obs_q.size() == 0) begin
        miscompares++;
        $display("FAIL rise_on_to: got no event, exp event at cyc=%0d", e.cyc);
      end else begin
        o = obs_q.pop_front();
        if (o.cyc !== e.cyc || o.vld !== e.vld || o.err !== e.err || o.to !== e.to || o.lck !== e.lck || (e.vld && o.per !== e.per)) begin
          miscompares++;
          $display("FAIL rise_on_to: got cyc=%0d per=%0d vld=%b err=%b to=%b lck=%b, exp cyc=%0d per=%0d vld=%b err=%b to=%b lck=%b",
                   o.cyc, o.per, o.vld, o.err, o.to, o.lck, e.cyc, e.per, e.vld, e.err, e.to, e.lck);
        end
      end
    end
    vectors++;
    if (obs_q.size() != 0) begin
      miscompares++;
      $display("FAIL rise_on_to_extra: got %0d unexpected events, exp 0", obs_q.size());
      obs_q.delete();
    end
  endtask

  task automatic test_async_reset();
    evt_t e, o;
    int   c0;
    vectors++;
    if (locked !== 1'b1) begin
      miscompares++;
      $display("FAIL pre_reset_locked: got %b, exp 1", locked);
    end
    c0 = cyc;
    #2 rst = 1'b1;
    #1;
    vectors++;
    if ({period, period_vld, locked, ratio_err, timeout} !== '0 || cyc != c0) begin
      miscompares++;
      $display("FAIL mid_lock_reset: got %b (edges %0d), exp 0 (edges 0)",
               {period, period_vld, locked, ratio_err, timeout}, cyc - c0);
    end
    repeat (2) @(negedge clk);
    rst = 1'b0;
    rise_hold(4, 0, 0, 0);
    rise_hold(4, 1, 0, 0);
    rise_hold(4, 1, 0, 0);
    rise_hold(4, 1, 0, 1);
    rise_hold(4, 1, 0, 1);
    for (int n = 0; n < 16 && obs_q.size() < exp_q.size(); n++) @(negedge clk);
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      vectors++;
      if (obs_q.size() == 0) begin
        miscompares++;
        $display("FAIL relock: got no event, exp event at cyc=%0d", e.cyc);
      end else begin
        o = obs_q.pop_front();
        if (o.cyc !== e.cyc || o.vld !== e.vld || o.err !== e.err || o.to !== e.to || o.lck !== e.lck || (e.vld && o.per !== e.per)) begin
          miscompares++;
          $display("FAIL relock: got cyc=%0d per=%0d vld=%b err=%b to=%b lck=%b, exp cyc=%0d per=%0d vld=%b err=%b to=%b lck=%b",
                   o.cyc, o.per, o.vld, o.err, o.to, o.lck, e.cyc, e.per, e.vld, e.err, e.to, e.lck);
        end
      end
    end
    vectors++;
    if (obs_q.size() != 0) begin
      miscompares++;
      $display("FAIL relock_extra: got %0d unexpected events, exp 0", obs_q.size());
      obs_q.delete();
    end
  endtask

  task automatic test_tolerance();
    evt_t e, o;
    use_t = 1'b1;
    rise_hold(3, 0, 0, 0);
    rise_hold(5, 1, 0, 0);
    rise_hold(3, 1, 0, 0);
    rise_hold(5, 1, 0, 1);
    rise_hold(3, 1, 0, 1);
    rise_hold(6, 1, 0, 1);
    rise_hold(16, 1, 1, 0);
    push_timeout();
    use_t = 1'b0;
    for (int n = 0; n < 16 && obs_t_q.size() < exp_t_q.size(); n++) @(negedge clk);
    while (exp_t_q.size() > 0) begin
      e = exp_t_q.pop_front();
      vectors++;
      if (obs_t_q.size() == 0) begin
        miscompares++;
        $display("FAIL tolerance: got no event, exp event at cyc=%0d", e.cyc);
      end else begin
        o = obs_t_q.pop_front();
        if (o.cyc !== e.cyc || o.vld !== e.vld || o.err !== e.err || o.to !== e.to || o.lck !== e.lck || (e.vld && o.per !== e.per)) begin
          miscompares++;
          $display("FAIL tolerance: got cyc=%0d per=%0d vld=%b err=%b to=%b lck=%b, exp cyc=%0d per=%0d vld=%b err=%b to=%b lck=%b",
                   o.cyc, o.per, o.vld, o.err, o.to, o.lck, e.cyc, e.per, e.vld, e.err, e.to, e.lck);
        end
      end
    end
    vectors++;
    if (obs_t_q.size() != 0) begin
      miscompares++;
      $display("FAIL tolerance_extra: got %0d unexpected events, exp 0", obs_t_q.size());
      obs_t_q.delete();
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation still running at time %0t, exp finished", $time);
    $fatal(1, "watchdog expired");
  end

  initial begin
    test_reset();
    test_steady();
    test_stretch();
    test_stall();
    test_rise_on_timeout();
    test_async_reset();
    test_tolerance();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
